count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
- Downstream consumer of the 8-bit free-running counter. Watches the counter output and its `counter_valid` / `enable` qualifiers.
- Captures each new count value and tags it with a wrap flag. Buffers captured words in a small FIFO.
- Delivers words over a valid/ready handshake to the next consumer (logger/monitor).
- Reports overflow when the consumer falls behind.

Parameters:
- WIDTH, 8, width of the counter value being captured.
- DEPTH, 8, FIFO depth in entries; must be a power of 2, minimum 2.
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- count_in  input  WIDTH  counter value from the upstream counter.
- enable  input  1  upstream counter enable; capture is qualified by it.
- counter_valid  input  1  upstream value-valid qualifier.
- clear_overflow  input  1  synchronous one-cycle clear of overflow and drop_count.
- out_data  output  WIDTH+1  {wrap, value} at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head word when out_valid && out_ready.
- level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set when a capture is dropped.
- drop_count  output  DROP_W  number of dropped captures, saturating at all-ones.

Behaviour:
- Reset (async, any time, including mid-transfer) forces these values:
  - out_valid=0, out_data=0, level=0, full=0, overflow=0, drop_count=0.
  - Read/write pointers=0; have_last=0; last=0.
- Capture condition, evaluated each rising edge: cap = counter_valid && enable && (!have_last || count_in != last).
- On cap:
  - last <= count_in; have_last <= 1.
  - This update happens whether or not the word is stored.
- Wrap flag: wrap = have_last && (count_in < last). Covers both counter roll-over (FF->00) and upstream reset to 0. The first capture after reset has wrap=0.
- Pop: pop = out_valid && out_ready. The head advances on that edge.
- Push: cap && (level < DEPTH || pop). Full with simultaneous pop accepts the new word, and level stays DEPTH.
- Drop: cap && level == DEPTH && !pop.
  - Word discarded; overflow <= 1.
  - drop_count increments and saturates at 2^DROP_W-1.
- Level update rules:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Pop when empty cannot occur, because out_valid gates it.
- Output timing:
  - First-word-fall-through: out_data = mem[rd_ptr], out_valid = (level != 0).
  - A word captured at edge N is visible on out_data/out_valid after edge N (one-cycle latency).
  - out_data is held stable while out_valid && !out_ready.
  - When empty, out_data is don't-care; the bench must not check it.
- clear_overflow:
  - When high at an edge: overflow <= 0 and drop_count <= 0.
  - If a drop occurs on the same edge: overflow <= 1, drop_count <= 1. The clear applies first, then the drop counts.
- Pointers wrap modulo DEPTH. Only level determines full/empty.
- enable=0 or counter_valid=0 blocks capture entirely. have_last/last are held, so a resumed identical value is not recaptured.

Test Plan:
- Reset, then counter_valid=1, enable=1, count_in steps 00..05 one per cycle, out_ready=1 -> out_data sequence 0x000..0x005, wrap=0, level never exceeds 1, overflow=0.
- Hold count_in=0x2A for 5 cycles, valid/enable high -> exactly one capture (0x02A), level=1.
- count_in steps FE, FF, 00, 01 with out_ready=1 -> outputs 0x0FE, 0x0FF, 0x100, 0x001 (wrap set only on 00).
- out_ready=0, feed 10 distinct values with DEPTH=8 -> level=8, full=1, overflow=1, drop_count=2. Drain with out_ready=1 -> first 8 values are returned in order.
- Full FIFO, out_ready=1 and a new capture on the same edge -> level stays 8, no drop, and the new word appears last. Then pulse clear_overflow on an edge with a drop -> overflow=1, drop_count=1.
- Assert reset asynchronously mid-stream with level=5 -> out_valid and level go to 0 immediately without waiting for a clock edge. The next capture after release carries wrap=0 even when its value is below the pre-reset last.

Source files
------------

// File: rtl/count_capture_fifo_if.sv
// Output stream of the count capture FIFO: {wrap, value} words over valid/ready.
interface count_capture_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0] out_data;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/count_capture_fifo.sv
// Captures each new upstream counter value with a wrap tag into a small FWFT FIFO,
// with sticky overflow and a saturating count of captures lost while full.
module count_capture_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     enable,
  input  logic                     counter_valid,
  input  logic                     clear_overflow,
  count_capture_fifo_if.master     o_stream,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_have_last;
  logic [WIDTH-1:0]     r_last;
  logic                 r_overflow;
  logic [DROP_W-1:0]    r_drop_count;

  logic w_cap, w_wrap, w_valid, w_full, w_pop, w_push, w_drop;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign w_cap   = counter_valid && enable && (!r_have_last || count_in != r_last);
  assign w_wrap  = r_have_last && (count_in < r_last);
  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_pop   = w_valid && o_stream.out_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_wrap, count_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_have_last  <= 1'b0;
      r_last       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      // last tracks every capture, stored or dropped, so repeats are never recaptured.
      if (w_cap) begin
        r_last      <= count_in;
        r_have_last <= 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      // Clear takes effect first, so a same-edge drop restarts the count at one.
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc(clear_overflow ? '0 : r_drop_count);
      end else if (clear_overflow) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  assign o_stream.out_valid = w_valid;
  assign o_stream.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign level              = r_level;
  assign full               = w_full;
  assign overflow           = r_overflow;
  assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: vector table, directed corner sequences, random vs queue model.
module tb_count_capture_fifo;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  count_in;
  logic              enable, counter_valid, clear_overflow;
  logic [LVL_W-1:0]  level;
  logic              full, overflow;
  logic [DROP_W-1:0] drop_count;

  count_capture_fifo_if #(.WIDTH(WIDTH)) s_if ();

  count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .count_in       (count_in),
    .enable         (enable),
    .counter_valid  (counter_valid),
    .clear_overflow (clear_overflow),
    .o_stream       (s_if),
    .level          (level),
    .full           (full),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       cv;
    logic       en;
    logic [7:0] cin;
    logic       rdy;
    logic       exp_vld;
    logic [8:0] exp_data;
    int         exp_lvl;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [8:0] mq[$];
  logic       m_have;
  logic [7:0] m_last;
  logic       m_ov;
  int         m_dc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic en, input logic [7:0] cin,
                       input logic rdy, input logic clr);
    counter_valid    = cv;
    enable           = en;
    count_in         = cin;
    s_if.out_ready   = rdy;
    clear_overflow   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    counter_valid  = 1'b0;
    enable         = 1'b0;
    count_in       = '0;
    s_if.out_ready = 1'b0;
    clear_overflow = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_have = 1'b0;
    m_last = '0;
    m_ov   = 1'b0;
    m_dc   = 0;
  endtask

  function automatic vec_t mk(input logic cv, input logic en, input logic [7:0] cin,
                              input logic rdy, input logic vld, input logic [8:0] d,
                              input int lvl);
    vec_t v;
    v.cv = cv; v.en = en; v.cin = cin; v.rdy = rdy;
    v.exp_vld = vld; v.exp_data = d; v.exp_lvl = lvl;
    return v;
  endfunction

  // One clock of the reference behaviour, from the state before the edge.
  task automatic model_step(input logic cv, input logic en, input logic [7:0] cin,
                            input logic rdy, input logic clr);
    logic cap, pop, wrap;
    int   sz;
    sz   = mq.size();
    cap  = cv && en && (!m_have || cin != m_last);
    pop  = (sz > 0) && rdy;
    wrap = m_have && (cin < m_last);
    if (clr) begin
      m_ov = 1'b0;
      m_dc = 0;
    end
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (sz < DEPTH || pop) mq.push_back({wrap, cin});
      else begin
        m_ov = 1'b1;
        m_dc = (m_dc == 255) ? 255 : m_dc + 1;
      end
      m_last = cin;
      m_have = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c;
    int         r;
    logic       cv, en, rdy, clr;

    // ---- reset state, checked before any clock edge ----
    reset = 1'b1; counter_valid = 0; enable = 0; count_in = 0;
    s_if.out_ready = 0; clear_overflow = 0;
    #3;
    chk("rst_valid", s_if.out_valid, 0);
    chk("rst_data",  s_if.out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_full",  full, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_drop",  drop_count, 0);
    do_reset();

    // ---- vector table ----
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, 8'(i), 1, 1, 9'(i), 1));
    tbl.push_back(mk(1, 1, 8'h2A, 1, 1, 9'h02A, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 8'h2A, 1, 0, 9'h000, 0));
    tbl.push_back(mk(1, 1, 8'hFE, 1, 1, 9'h0FE, 1));
    tbl.push_back(mk(1, 1, 8'hFF, 1, 1, 9'h0FF, 1));
    tbl.push_back(mk(1, 1, 8'h00, 1, 1, 9'h100, 1));
    tbl.push_back(mk(1, 1, 8'h01, 1, 1, 9'h001, 1));
    tbl.push_back(mk(0, 1, 8'h77, 1, 0, 9'h000, 0));
    tbl.push_back(mk(1, 0, 8'h50, 1, 0, 9'h000, 0));
    tbl.push_back(mk(1, 1, 8'h01, 1, 0, 9'h000, 0));
    tbl.push_back(mk(1, 1, 8'h02, 1, 1, 9'h002, 1));
    tbl.push_back(mk(1, 1, 8'h00, 0, 1, 9'h002, 2));
    tbl.push_back(mk(0, 1, 8'h00, 1, 1, 9'h100, 1));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 9'h000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].en, tbl[i].cin, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_valid", i), s_if.out_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_lvl);
      chk($sformatf("tbl%0d_full", i), full, 0);
      chk($sformatf("tbl%0d_ovf", i), overflow, 0);
      chk($sformatf("tbl%0d_drop", i), drop_count, 0);
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_data", i), s_if.out_data, tbl[i].exp_data);
    end

    // ---- fill past full: 10 values, 2 dropped, drain first 8 in order ----
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, 1, 8'(8'h10 + i), 0, 0);
    chk("ovf10_level", level, 8);
    chk("ovf10_full",  full, 1);
    chk("ovf10_ovf",   overflow, 1);
    chk("ovf10_drop",  drop_count, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), s_if.out_data, 9'(9'h010 + i));
      drive(0, 1, 8'h00, 1, 0);
    end
    chk("drain_level", level, 0);
    chk("drain_valid", s_if.out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // ---- full with simultaneous pop and capture; clear colliding with drop ----
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 1, 8'(8'h20 + i), 0, 0);
    chk("fullpop_pre_level", level, 8);
    drive(1, 1, 8'h28, 1, 0);
    chk("fullpop_level", level, 8);
    chk("fullpop_ovf",   overflow, 0);
    chk("fullpop_drop",  drop_count, 0);
    chk("fullpop_head",  s_if.out_data, 9'h021);
    drive(1, 1, 8'h29, 0, 0);
    drive(1, 1, 8'h2A, 0, 0);
    chk("drop2_count", drop_count, 2);
    drive(1, 1, 8'h2B, 0, 1);
    chk("clrdrop_ovf",  overflow, 1);
    chk("clrdrop_drop", drop_count, 1);
    drive(0, 1, 8'h00, 0, 1);
    chk("clr_ovf",  overflow, 0);
    chk("clr_drop", drop_count, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fpdrain%0d_data", i), s_if.out_data, 9'(9'h021 + i));
      drive(0, 1, 8'h00, 1, 0);
    end
    chk("fpdrain_level", level, 0);

    // ---- drop counter saturation ----
    do_reset();
    for (int i = 0; i < 308; i++) drive(1, 1, 8'(i), 0, 0);
    chk("sat_drop",  drop_count, 255);
    chk("sat_ovf",   overflow, 1);
    chk("sat_level", level, 8);

    // ---- asynchronous reset mid-stream ----
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 1, 8'(8'h60 + i), 0, 0);
    chk("arst_pre_level", level, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", s_if.out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_ovf",   overflow, 0);
    #1 reset = 1'b0;
    drive(1, 1, 8'h05, 0, 0);
    chk("arst_next_level", level, 1);
    chk("arst_next_data",  s_if.out_data, 9'h005);

    // ---- randomized against the queue model ----
    do_reset();
    c = '0;
    for (int n = 0; n < 3000; n++) begin
      cv  = ($urandom_range(0, 9) < 8);
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < (n % 600 < 300 ? 5 : 2));
      clr = ($urandom_range(0, 39) == 0);
      r   = $urandom_range(0, 9);
      if (r >= 7)      c = 8'($urandom_range(0, 255));
      else if (r >= 3) c = c + 8'd1;
      model_step(cv, en, c, rdy, clr);
      drive(cv, en, c, rdy, clr);
      chk("rnd_valid", s_if.out_valid, (mq.size() != 0));
      chk("rnd_level", level, mq.size());
      chk("rnd_full",  full, (mq.size() == DEPTH));
      chk("rnd_ovf",   overflow, m_ov);
      chk("rnd_drop",  drop_count, m_dc);
      if (mq.size() != 0) chk("rnd_data", s_if.out_data, mq[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
